// File: rtl/video_pattern_gen.sv
// Test-pattern generator: maps sync-core pixel coordinates to an RGB colour through a
// two-stage pipeline, with frame-synchronous double-buffered configuration and horizontal scroll.
module video_pattern_gen #(
    parameter int COLOR_W    = 4,
    parameter int H_DISPLAY  = 640,
    parameter int V_DISPLAY  = 480,
    parameter int GRAY_SHIFT = 5,
    parameter int PRIM_SHIFT = 6,
    parameter int RB_SHIFT   = 7,
    parameter int CHK_SHIFT  = 5,
    parameter int SCROLL_DIV = 1,
    parameter int H_SIZE     = 11,
    parameter int V_SIZE     = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [H_SIZE-1:0]      hc,
    input  logic [V_SIZE-1:0]      vc,
    input  logic                   cfg_wr,
    input  logic [2:0]             cfg_mode,
    input  logic [3*COLOR_W-1:0]   cfg_color,
    input  logic                   cfg_scroll_en,
    input  logic [H_SIZE-1:0]      cfg_step,
    output logic                   cfg_pending,
    output logic [3*COLOR_W-1:0]   rgb
);

    localparam int CW3   = 3 * COLOR_W;
    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [H_SIZE:0]   H_DISP_W = (H_SIZE+1)'(H_DISPLAY);
    localparam logic [V_SIZE-1:0] V_DISP_W = V_SIZE'(V_DISPLAY);
    localparam logic [V_SIZE-1:0] V_BAND1  = V_SIZE'(V_DISPLAY / 3);
    localparam logic [V_SIZE-1:0] V_BAND2  = V_SIZE'(2 * (V_DISPLAY / 3));
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCROLL_DIV - 1);

    function automatic logic [CW3-1:0] rainbow_px(input logic [2:0] seg,
                                                   input logic [COLOR_W-1:0] ramp);
        logic [COLOR_W-1:0] up, dn, on, zr;
        up = ramp;
        dn = ~ramp;
        on = '1;
        zr = '0;
        case (seg)
            3'd0:    rainbow_px = {on, up, zr};
            3'd1:    rainbow_px = {dn, on, zr};
            3'd2:    rainbow_px = {zr, on, up};
            3'd3:    rainbow_px = {zr, dn, on};
            3'd4:    rainbow_px = {up, zr, on};
            3'd5:    rainbow_px = {on, zr, dn};
            default: rainbow_px = {on, on, on};
        endcase
    endfunction

    function automatic logic [CW3-1:0] pixel_color(input logic [2:0]         mode,
                                                    input logic [CW3-1:0]     color,
                                                    input logic [COLOR_W-1:0] gray,
                                                    input logic [2:0]         prim,
                                                    input logic [2:0]         seg,
                                                    input logic [COLOR_W-1:0] ramp,
                                                    input logic               chk,
                                                    input logic [1:0]         band);
        logic [CW3-1:0] gray_c, prim_c, rb_c;
        gray_c = {gray, gray, gray};
        prim_c = {{COLOR_W{prim[2]}}, {COLOR_W{prim[1]}}, {COLOR_W{prim[0]}}};
        rb_c   = rainbow_px(seg, ramp);
        case (mode)
            3'd0: begin
                case (band)
                    2'd0:    pixel_color = gray_c;
                    2'd1:    pixel_color = prim_c;
                    default: pixel_color = rb_c;
                endcase
            end
            3'd1:    pixel_color = gray_c;
            3'd2:    pixel_color = prim_c;
            3'd3:    pixel_color = rb_c;
            3'd4:    pixel_color = chk ? '1 : '0;
            3'd5:    pixel_color = color;
            default: pixel_color = '0;
        endcase
    endfunction

    logic [2:0]         mode_s, mode_a, mode_n;
    logic [CW3-1:0]     color_s, color_a, color_n;
    logic               scroll_en_s, scroll_en_a, scroll_en_n;
    logic [H_SIZE-1:0]  step_s, step_a, step_n;
    logic [H_SIZE-1:0]  x_off, x_off_n;
    logic [DIV_W-1:0]   div_cnt, div_n;
    logic               pending_n;
    logic               fs, apply;
    logic [H_SIZE:0]    off_sum, off_wrap, x_sum, x_wrap;
    logic               blank;

    logic [H_SIZE-1:0]  x_p1;
    logic [V_SIZE-1:0]  vc_p1;
    logic               vld_p1;
    logic [2:0]         mode_p1;
    logic [CW3-1:0]     color_p1;

    // Frame-start apply of shadow config, scroll offset update and effective column
    always_comb begin
        fs          = (hc == '0) && (vc == '0);
        apply       = fs && cfg_pending;
        mode_n      = apply ? mode_s      : mode_a;
        color_n     = apply ? color_s     : color_a;
        scroll_en_n = apply ? scroll_en_s : scroll_en_a;
        step_n      = apply ? step_s      : step_a;
        pending_n   = cfg_wr ? 1'b1 : (apply ? 1'b0 : cfg_pending);

        off_sum  = {1'b0, x_off} + {1'b0, step_n};
        off_wrap = (off_sum >= H_DISP_W) ? off_sum - H_DISP_W : off_sum;
        x_off_n  = x_off;
        div_n    = div_cnt;
        if (fs) begin
            if (!scroll_en_n) begin
                x_off_n = '0;
                div_n   = '0;
            end else if (div_cnt == DIV_LAST) begin
                div_n   = '0;
                x_off_n = off_wrap[H_SIZE-1:0];
            end else begin
                div_n   = div_cnt + 1'b1;
            end
        end

        x_sum  = {1'b0, hc} + {1'b0, x_off_n};
        x_wrap = (x_sum >= H_DISP_W) ? x_sum - H_DISP_W : x_sum;
        blank  = ({1'b0, hc} >= H_DISP_W) || (vc >= V_DISP_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_pending <= 1'b0;
            mode_s      <= '0;
            color_s     <= '0;
            scroll_en_s <= 1'b0;
            step_s      <= '0;
            mode_a      <= '0;
            color_a     <= '0;
            scroll_en_a <= 1'b0;
            step_a      <= '0;
            x_off       <= '0;
            div_cnt     <= '0;
        end else begin
            if (cfg_wr) begin
                mode_s      <= cfg_mode;
                color_s     <= cfg_color;
                scroll_en_s <= cfg_scroll_en;
                step_s      <= cfg_step;
            end
            cfg_pending <= pending_n;
            mode_a      <= mode_n;
            color_a     <= color_n;
            scroll_en_a <= scroll_en_n;
            step_a      <= step_n;
            x_off       <= x_off_n;
            div_cnt     <= div_n;
        end
    end

    // Stage 1: effective column, row, visibility and config snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            x_p1     <= '0;
            vc_p1    <= '0;
            vld_p1   <= 1'b0;
            mode_p1  <= '0;
            color_p1 <= '0;
        end else begin
            x_p1     <= x_wrap[H_SIZE-1:0];
            vc_p1    <= vc;
            vld_p1   <= !blank;
            mode_p1  <= mode_n;
            color_p1 <= color_n;
        end
    end

    logic [COLOR_W-1:0] gray_lvl, rb_ramp;
    logic [2:0]         prim_idx, rb_seg;
    logic               chk_bit;
    logic [1:0]         band;

    always_comb begin
        gray_lvl = x_p1[GRAY_SHIFT+COLOR_W-1:GRAY_SHIFT];
        prim_idx = x_p1[PRIM_SHIFT+2:PRIM_SHIFT];
        rb_seg   = x_p1[RB_SHIFT+2:RB_SHIFT];
        rb_ramp  = x_p1[RB_SHIFT-1:RB_SHIFT-COLOR_W];
        chk_bit  = x_p1[CHK_SHIFT] ^ vc_p1[CHK_SHIFT];
        if (vc_p1 < V_BAND1)      band = 2'd0;
        else if (vc_p1 < V_BAND2) band = 2'd1;
        else                      band = 2'd2;
    end

    // Stage 2: colour function
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb <= '0;
        end else begin
            rgb <= vld_p1 ? pixel_color(mode_p1, color_p1, gray_lvl, prim_idx,
                                        rb_seg, rb_ramp, chk_bit, band) : '0;
        end
    end

endmodule
